// File: rtl/light_sequencer.sv
// Intersection phase sequencer: owns the cycle counter and pedestrian latch,
// steps the light phases on generator enables and trips a latched fault on counter overrun.
module light_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ped_btn,
  output logic [5:0] counter,
  output logic       ped,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       fault
);

  localparam logic [2:0] MG    = 3'd0;
  localparam logic [2:0] MY    = 3'd1;
  localparam logic [2:0] AR1   = 3'd2;
  localparam logic [2:0] SG    = 3'd3;
  localparam logic [2:0] SY    = 3'd4;
  localparam logic [2:0] AR2   = 3'd5;
  localparam logic [2:0] WALK  = 3'd6;
  localparam logic [2:0] FAULT = 3'd7;

  localparam logic [5:0] CNT_MAX = 6'd63;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  logic [2:0] state_reg, state_next;
  logic [5:0] counter_reg, counter_next;
  logic       ped_reg, ped_next;
  logic       ped_pending_reg, ped_pending_next;
  logic       enters_mg;

  always_comb begin
    state_next = state_reg;
    if (enable) begin
      case (state_reg)
        MG:      state_next = MY;
        MY:      state_next = AR1;
        AR1:     state_next = SG;
        SG:      state_next = SY;
        SY:      state_next = AR2;
        AR2:     state_next = ped_reg ? WALK : MG;
        WALK:    state_next = MG;
        default: state_next = FAULT;
      endcase
    end
    enters_mg = (state_next == MG) && (state_reg != MG);
    // An MG entry on the overrun edge restarts the cycle instead of faulting.
    if ((state_reg != FAULT) && !enters_mg && (counter_reg == CNT_MAX)) begin
      state_next = FAULT;
    end
  end

  always_comb begin
    counter_next = counter_reg;
    if (enters_mg) begin
      counter_next = 6'd0;
    end else if (counter_reg != CNT_MAX) begin
      counter_next = counter_reg + 6'd1;
    end
  end

  // The request is sampled at count 0 so ped stays constant for a whole phase cycle.
  always_comb begin
    ped_next         = ped_reg;
    ped_pending_next = ped_pending_reg;
    if (state_reg != FAULT) begin
      if (counter_reg == 6'd0) begin
        ped_next         = ped_pending_reg | ped_btn;
        ped_pending_next = 1'b0;
      end else begin
        ped_pending_next = ped_pending_reg | ped_btn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= MG;
      counter_reg     <= 6'd0;
      ped_reg         <= 1'b0;
      ped_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      counter_reg     <= counter_next;
      ped_reg         <= ped_next;
      ped_pending_reg <= ped_pending_next;
    end
  end

  always_comb begin
    main_light = LAMP_R;
    side_light = LAMP_R;
    case (state_reg)
      MG:      main_light = LAMP_G;
      MY:      main_light = LAMP_Y;
      SG:      side_light = LAMP_G;
      SY:      side_light = LAMP_Y;
      default: ;
    endcase
  end

  assign walk    = (state_reg == WALK);
  assign fault   = (state_reg == FAULT);
  assign counter = counter_reg;
  assign ped     = ped_reg;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with a behavioural equal-traffic timing generator
// closing the counter -> enable loop.
module tb_light_sequencer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       ped_btn;
  logic [5:0] counter;
  logic       ped;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       fault;

  logic gen_on;
  logic skip29;
  logic force_en;

  int tests_run;
  int tests_failed;

  light_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .ped_btn    (ped_btn),
    .counter    (counter),
    .ped        (ped),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timing generator model: enables at 11,13,15,25,27,29 and 39 when ped is set.
  always_comb begin
    enable = force_en;
    if (gen_on) begin
      case (counter)
        6'd11, 6'd13, 6'd15, 6'd25, 6'd27: enable = 1'b1;
        6'd29: if (!skip29) enable = 1'b1;
        6'd39: if (ped) enable = 1'b1;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_main(input int c);
    if (c <= 11) return 3'b001;
    if (c <= 13) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_side(input int c);
    if (c >= 16 && c <= 25) return 3'b001;
    if (c >= 26 && c <= 27) return 3'b010;
    return 3'b100;
  endfunction

  // One full phase cycle starting at count 0; optional button press at count press_at.
  task automatic run_period(input int len, input logic exp_ped, input int press_at);
    for (int c = 0; c < len; c++) begin
      ped_btn = (c == press_at);
      check($sformatf("cnt@%0d", c), 32'(counter), 32'(c));
      check($sformatf("main@%0d", c), 32'(main_light), 32'(exp_main(c)));
      check($sformatf("side@%0d", c), 32'(side_light), 32'(exp_side(c)));
      check($sformatf("walk@%0d", c), 32'(walk), 32'(c >= 30));
      check($sformatf("fault@%0d", c), 32'(fault), 32'd0);
      if (c >= 1) check($sformatf("ped@%0d", c), 32'(ped), 32'(exp_ped));
      @(negedge clk);
    end
    ped_btn = 1'b0;
    $display("[TB] period len=%0d ped=%0b press=%0d done", len, exp_ped, press_at);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cnt"}, 32'(counter), 32'd0);
    check({tag, "_ped"}, 32'(ped), 32'd0);
    check({tag, "_main"}, 32'(main_light), 32'b001);
    check({tag, "_side"}, 32'(side_light), 32'b100);
    check({tag, "_walk"}, 32'(walk), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b1;
    ped_btn  = 1'b0;
    gen_on   = 1'b1;
    skip29   = 1'b0;
    force_en = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    $display("[TB] reset state checked");

    // Equal-traffic schedule, no button, three periods of 30.
    repeat (3) run_period(30, 1'b0, -1);

    // Press at count 5: effective next cycle, WALK at 30..39, then cleared.
    run_period(30, 1'b0, 5);
    run_period(40, 1'b1, -1);
    run_period(30, 1'b0, -1);

    // Press at count 0: counts for the same cycle, nothing left pending.
    run_period(40, 1'b1, 0);
    run_period(30, 1'b0, -1);

    // Reset during SG at count 20 with a request pending.
    for (int c = 0; c <= 20; c++) begin
      ped_btn = (c == 18);
      check($sformatf("pre_rst_cnt@%0d", c), 32'(counter), 32'(c));
      if (c == 20) reset = 1'b1;
      @(negedge clk);
    end
    ped_btn = 1'b0;
    reset   = 1'b0;
    check_reset_state("midrst");
    $display("[TB] mid-operation reset checked");
    run_period(30, 1'b0, -1);

    // Enable into MG on the same edge as counter=63 wins over the watchdog.
    skip29 = 1'b1;
    for (int c = 0; c < 63; c++) @(negedge clk);
    check("ar2_cnt63", 32'(counter), 32'd63);
    check("ar2_main", 32'(main_light), 32'b100);
    check("ar2_side", 32'(side_light), 32'b100);
    check("ar2_fault", 32'(fault), 32'd0);
    force_en = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    skip29   = 1'b0;
    check("rescue_cnt", 32'(counter), 32'd0);
    check("rescue_main", 32'(main_light), 32'b001);
    check("rescue_fault", 32'(fault), 32'd0);
    $display("[TB] enable at count 63 rescue checked");
    run_period(30, 1'b0, -1);

    // Watchdog: no enables from reset.
    gen_on = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("wd_rst");
    for (int c = 0; c < 63; c++) @(negedge clk);
    check("wd_cnt63", 32'(counter), 32'd63);
    check("wd_fault_pre", 32'(fault), 32'd0);
    check("wd_main_pre", 32'(main_light), 32'b001);
    @(negedge clk);
    check("wd_fault", 32'(fault), 32'd1);
    check("wd_main", 32'(main_light), 32'b100);
    check("wd_side", 32'(side_light), 32'b100);
    for (int i = 0; i < 20; i++) begin
      force_en = (i % 2 == 0);
      ped_btn  = (i % 3 == 0);
      @(negedge clk);
      check($sformatf("wd_hold_fault@%0d", i), 32'(fault), 32'd1);
      check($sformatf("wd_hold_main@%0d", i), 32'(main_light), 32'b100);
      check($sformatf("wd_hold_side@%0d", i), 32'(side_light), 32'b100);
      check($sformatf("wd_hold_walk@%0d", i), 32'(walk), 32'd0);
      check($sformatf("wd_hold_cnt@%0d", i), 32'(counter), 32'd63);
    end
    force_en = 1'b0;
    ped_btn  = 1'b0;
    $display("[TB] fault hold checked");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("wd_exit");
    $display("[TB] fault exit by reset checked");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
# light_sequencer

Phase sequencer for the intersection controller. It owns the 6-bit cycle counter and the pedestrian-request latch, and drives both into the timing-enable generator. It advances a light-phase state machine on each single-cycle `enable` pulse returned by that generator, and decodes the phase into main/side lamp and walk outputs. A counter watchdog forces a latched all-red fault if the generator stops issuing enables.

## Interface
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; returns every register to its reset value.
- `enable` input 1: phase-advance pulse from the timing generator; combinational function of `counter` and `ped`.
- `ped_btn` input 1: pedestrian push-button, already synchronised; any-length pulse.
- `counter` output 6: cycle counter fed to the timing generator; reset 0.
- `ped` output 1: pedestrian phase requested for the current cycle, stable for the whole cycle; reset 0.
- `main_light` output 3: one-hot {R,Y,G}, bit 2 = red; reset 3'b001 (green).
- `side_light` output 3: one-hot {R,Y,G}; reset 3'b100 (red).
- `walk` output 1: walk lamp; reset 0.
- `fault` output 1: watchdog tripped; reset 0.

## Operation
- State machine: MG, MY, AR1, SG, SY, AR2, WALK, FAULT; reset state is MG.
- Transitions on `enable`=1:
  - MG→MY, MY→AR1, AR1→SG, SG→SY, SY→AR2.
  - AR2→WALK if `ped`=1, else AR2→MG.
  - WALK→MG.
  - Without `enable`, the state holds.
- Lamp decode (Moore, from registered state only):
  - MG: main G, side R.
  - MY: main Y, side R.
  - AR1, AR2, WALK, FAULT: both R.
  - SG: side G, main R.
  - SY: side Y, main R.
  - `walk`=1 only in WALK.
- Counter:
  - On an edge that transitions into MG, `counter` loads 0.
  - Otherwise it increments by 1 each cycle.
  - It never wraps. When `counter`=63 and no transition into MG occurs on that edge, the next state is FAULT and `counter` holds at 63.
- Pedestrian latch:
  - `ped_pending` sets on any cycle with `ped_btn`=1.
  - On the edge where `counter`=0, `ped` loads `ped_pending | ped_btn` and `ped_pending` clears in the same edge.
  - A press at `counter`=0 therefore counts for the current cycle.
  - A press at any other count counts for the next cycle.
  - `ped` is otherwise held.
- FAULT:
  - Absorbing state; only `reset` exits it.
  - `fault`=1, both directions red, `walk`=0, `enable` and `ped_btn` ignored.
- Simultaneous events:
  - `reset` overrides everything.
  - `enable` in FAULT is ignored.
  - An `enable` into MG on the same edge as `counter`=63 wins: no fault, `counter` loads 0.

## Timing
- All outputs are registered or decoded from registered state. The lamp change is visible the cycle after the edge at which `enable`=1 is sampled.
- Zero-latency loop: `counter` → generator → `enable` is combinational within one cycle. The block must not register `enable`.
- Reference cycle with the generator's equal-traffic schedule (enables at 11,13,15,25,27,29):
  - MG at counts 0–11, MY at 12–13, AR1 at 14–15.
  - SG at 16–25, SY at 26–27, AR2 at 28–29.
  - Count returns to 0 in MG; period is 30 clocks.
- With `ped`=1 the generator adds an enable at 39: WALK occupies counts 30–39 and the period is 40.
- `fault` asserts the cycle after `counter`=63 is sampled with no MG entry.
- Reset mid-operation: the cycle after `reset` is sampled high, the state is MG, `counter`=0, `ped`=0, `ped_pending`=0, `fault`=0.

## Test plan
- Equal-traffic enables at 11,13,15,25,27,29, no button → `main_light` 001 for counts 0–11, 010 at 12–13, 100 from 14. `side_light` 001 at 16–25. `counter` returns to 0 after 29; period 30, repeated 3 cycles.
- Press `ped_btn` at count 5, generator adds an enable at 39 when `ped`=1 → current cycle unchanged. Next cycle `ped`=1, `walk`=1 at counts 30–39, MG at count 0 afterwards, and the following cycle has `ped`=0.
- Press `ped_btn` exactly at count 0 → `ped`=1 for that same cycle and `ped_pending` is 0 afterwards.
- Hold `enable`=0 from reset → `counter` rises to 63, `fault`=1 on the next cycle, both directions red. Subsequent `enable` pulses and button presses are ignored for 20 cycles; `reset` restores MG with `counter`=0.
- Assert `reset` during SG at count 20 with `ped_pending`=1 → next cycle MG, `counter`=0, `ped`=0, pending cleared, `walk`=0.
- Force `enable`=1 in AR2 at count 63 with `ped`=0 → MG entered, `counter`=0, `fault` stays 0.
